// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-side blocks: FSM states, status word
// layout and default timing constants.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      DATA,
      PARITY,
      STOP,
      ACKW,
      WAITIDLE
   } ps2_state_t;

   localparam int ST_DONE    = 11;
   localparam int ST_TIMEOUT = 10;
   localparam int ST_NACK    = 9;
   localparam int ST_BUSY    = 8;

   localparam int DEF_INHIBIT_CYCLES = 10000;    // 100 us at 100 MHz
   localparam int DEF_TIMEOUT_CYCLES = 1500000;  // 15 ms at 100 MHz

   function automatic logic odd_parity(input logic [7:0] i_byte);
      return ~^i_byte;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS2C/PS2D pads plus a one-cycle pulse on each
// falling edge of the synchronised clock line.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_ps2c,
   input  logic i_ps2d,
   output logic o_ps2c,
   output logic o_ps2d,
   output logic o_fall
);

   logic [1:0] r_c_sync;
   logic [1:0] r_d_sync;
   logic       r_c_prev;

   // Idle bus level is high, so the chain resets to 1 and reset release cannot
   // fake a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_c_sync <= 2'b11;
         r_d_sync <= 2'b11;
         r_c_prev <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let each flop take its neighbour's old value, forming a true shift chain.
         r_c_sync <= {r_c_sync[0], i_ps2c};
         r_d_sync <= {r_d_sync[0], i_ps2d};
         r_c_prev <= r_c_sync[1];
      end
   end

   assign o_ps2c = r_c_sync[1];
   assign o_ps2d = r_d_sync[1];
   assign o_fall = r_c_prev & ~r_c_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter on the Wishbone-style bus: a CPU write starts a
// request-to-send frame; status and a level completion interrupt report the outcome.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        STB,
   input  logic        WE,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   output logic        ACK,
   output logic        INT,
   input  logic        ps2c_i,
   input  logic        ps2d_i,
   output logic        ps2c_oe,
   output logic        ps2d_oe
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] INH_END  = CW'(INHIBIT_CYCLES);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

   ps2_state_t    r_state;
   logic [7:0]    r_byte;
   logic [2:0]    r_bit;
   logic [CW-1:0] r_cnt;
   logic          r_busy, r_done, r_timeout, r_nack;
   logic          r_c_oe, r_d_oe;
   logic          r_wr_d, r_rd_d;

   logic w_wr, w_rd, w_wr_evt, w_rd_evt;
   logic w_c_sync, w_d_sync, w_fall, w_timeout;
   logic w_unused_dat;

   ps2_line_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .i_ps2c (ps2c_i),
      .i_ps2d (ps2d_i),
      .o_ps2c (w_c_sync),
      .o_ps2d (w_d_sync),
      .o_fall (w_fall)
   );

   assign w_wr         = STB & WE;
   assign w_rd         = STB & ~WE;
   assign w_wr_evt     = w_wr & ~r_wr_d;
   assign w_rd_evt     = w_rd & ~r_rd_d;
   assign w_timeout    = (r_state inside {DATA, PARITY, STOP, ACKW, WAITIDLE}) && (r_cnt == TO_LAST);
   assign w_unused_dat = ^DAT_I[31:8];

   assign ACK     = STB;
   assign INT     = r_done;
   assign ps2c_oe = r_c_oe;
   assign ps2d_oe = r_d_oe;

   always_comb begin
      // NOTE: default every bit before the selective writes so no latch is inferred.
      DAT_O             = '0;
      DAT_O[7:0]        = r_byte;
      DAT_O[ST_BUSY]    = r_busy;
      DAT_O[ST_NACK]    = r_nack;
      DAT_O[ST_TIMEOUT] = r_timeout;
      DAT_O[ST_DONE]    = r_done;
   end

   // Asynchronous reset releases both open-drain lines at once, even mid-frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_byte    <= '0;
         r_bit     <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         r_nack    <= 1'b0;
         r_c_oe    <= 1'b0;
         r_d_oe    <= 1'b0;
         r_wr_d    <= 1'b0;
         r_rd_d    <= 1'b0;
      end else begin
         r_wr_d <= w_wr;
         r_rd_d <= w_rd;
         if (w_rd_evt) r_done <= 1'b0;
         if (r_state != IDLE) r_cnt <= r_cnt + 1'b1;

         if (w_timeout) begin
            r_c_oe    <= 1'b0;
            r_d_oe    <= 1'b0;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
         end else begin
            case (r_state)
               IDLE: if (w_wr_evt) begin
                  r_byte    <= DAT_I[7:0];
                  r_done    <= 1'b0;
                  r_timeout <= 1'b0;
                  r_nack    <= 1'b0;
                  r_busy    <= 1'b1;
                  r_c_oe    <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= INHIBIT;
               end
               INHIBIT: begin
                  // Start bit goes out one cycle before the clock line is released.
                  if (r_cnt == INH_LAST) r_d_oe <= 1'b1;
                  if (r_cnt == INH_END) begin
                     r_c_oe  <= 1'b0;
                     r_cnt   <= '0;
                     r_bit   <= '0;
                     r_state <= DATA;
                  end
               end
               DATA: if (w_fall) begin
                  r_d_oe <= ~r_byte[r_bit];
                  r_bit  <= r_bit + 3'd1;
                  if (r_bit == 3'd7) r_state <= PARITY;
               end
               PARITY: if (w_fall) begin
                  r_d_oe  <= ~odd_parity(r_byte);
                  r_state <= STOP;
               end
               STOP: if (w_fall) begin
                  r_d_oe  <= 1'b0;
                  r_state <= ACKW;
               end
               ACKW: if (w_fall) begin
                  if (w_d_sync) r_nack <= 1'b1;
                  r_state <= WAITIDLE;
               end
               WAITIDLE: if (w_c_sync && w_d_sync) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames, bus reads
// are scored against an expectation queue by an independent monitor.
module tb_ps2_host_tx;

   localparam int INH = 100;
   localparam int TO  = 5000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        STB = 1'b0;
   logic        WE  = 1'b0;
   logic [31:0] DAT_I = '0;
   logic [31:0] DAT_O;
   logic        ACK, INT;
   logic        ps2c_oe, ps2d_oe;
   logic        ps2c_i, ps2d_i;
   logic        dev_c = 1'b1;
   logic        dev_d = 1'b1;

   // Open-drain pads with pull-ups: either side can pull low.
   assign ps2c_i = ~ps2c_oe & dev_c;
   assign ps2d_i = ~ps2d_oe & dev_d;

   always #5 clk = ~clk;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk     (clk),
      .rst     (rst),
      .STB     (STB),
      .WE      (WE),
      .DAT_I   (DAT_I),
      .DAT_O   (DAT_O),
      .ACK     (ACK),
      .INT     (INT),
      .ps2c_i  (ps2c_i),
      .ps2d_i  (ps2d_i),
      .ps2c_oe (ps2c_oe),
      .ps2d_oe (ps2d_oe)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_inh    = 0;
   int c_len, d_at, to_len;

   logic [31:0] rd_q[$];
   string       rd_name_q[$];
   logic [9:0]  fr_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Read monitor: scores DAT_O once per read access, mid-cycle, against the queue.
   logic mon_prev = 1'b0;
   logic c_prev   = 1'b0;
   always @(negedge clk) begin
      string nm;
      mon_prev <= STB & ~WE;
      c_prev   <= ps2c_oe;
      if (ps2c_oe === 1'b1 && c_prev !== 1'b1) n_inh <= n_inh + 1;
      if (STB && !WE && !mon_prev) begin
         if (rd_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_read: got 0x%0h expected no read", DAT_O);
         end else begin
            nm = rd_name_q.pop_front();
            check(nm, DAT_O, rd_q.pop_front());
            check({nm, "_ack"}, {31'b0, ACK}, 32'd1);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [7:0] v, input int hold);
      STB   = 1'b1;
      WE    = 1'b1;
      DAT_I = {24'hA5A5A5, v};
      tick(hold);
      STB   = 1'b0;
      WE    = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] exp, input string name);
      rd_q.push_back(exp);
      rd_name_q.push_back(name);
      STB = 1'b1;
      WE  = 1'b0;
      tick(1);
      STB = 1'b0;
      tick(1);
   endtask

   function automatic logic cond(input int sel);
      case (sel)
         0:       return ps2c_oe === 1'b1;
         1:       return ps2c_oe === 1'b0 && ps2d_oe === 1'b1;
         2:       return DAT_O[8] === 1'b0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int limit, input string name);
      int n = 0;
      while (!cond(sel) && n < limit) begin
         tick(1);
         n++;
      end
      if (!cond(sel)) begin
         n_checks++;
         $display("FAIL %s: condition not reached within %0d cycles", name, limit);
      end
   endtask

   // Device: 11 clocks at a 50-cycle half-period, samples PS2D on rising edges,
   // optionally pulls PS2D low across the 11th clock as the acknowledge.
   task automatic device_frame(input logic do_ack, input string name);
      logic [9:0] got = '0;
      wait_for(0, 50, {name, "_inhibit"});
      wait_for(1, 200, {name, "_release"});
      tick(20);
      for (int k = 0; k < 11; k++) begin
         if (k == 10 && do_ack) dev_d = 1'b0;
         dev_c = 1'b0;
         tick(50);
         dev_c = 1'b1;
         if (k < 10) got[k] = ps2d_i;
         tick(50);
      end
      dev_d = 1'b1;
      if (fr_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s_frame: got 0x%0h expected no frame", name, got);
      end else begin
         check({name, "_frame"}, {22'b0, got}, {22'b0, fr_q.pop_front()});
      end
   endtask

   task automatic measure_inhibit(output int len, output int d_idx);
      len   = 0;
      d_idx = -1;
      wait_for(0, 50, "measure_inhibit_start");
      while (ps2c_oe === 1'b1 && len < 1000) begin
         if (ps2d_oe === 1'b1 && d_idx < 0) d_idx = len;
         len++;
         tick(1);
      end
   endtask

   initial begin
      int inh_before;
      tick(5);
      check("rst_ps2c_oe", {31'b0, ps2c_oe}, 32'd0);
      check("rst_ps2d_oe", {31'b0, ps2d_oe}, 32'd0);
      check("rst_dat_o", DAT_O, 32'h0);
      check("rst_int", {31'b0, INT}, 32'd0);
      rst = 1'b0;
      tick(5);

      // 0xED acked: bits 1,0,1,1,0,1,1,1 then parity 1, stop 1
      fr_q.push_back(10'h3ED);
      fork
         bus_write(8'hED, 1);
         device_frame(1'b1, "ed");
         measure_inhibit(c_len, d_at);
      join
      check("ed_clk_inhibit_len", c_len, 32'd101);
      check("ed_start_bit_cycle", d_at, 32'd100);
      wait_for(2, 300, "ed_done");
      check("ed_int", {31'b0, INT}, 32'd1);
      bus_read(32'h8ED, "ed_status");
      bus_read(32'h0ED, "ed_status_after_read");
      check("ed_int_cleared", {31'b0, INT}, 32'd0);

      // 0xF4 acked: parity bit 0
      fr_q.push_back(10'h2F4);
      fork
         bus_write(8'hF4, 1);
         device_frame(1'b1, "f4");
      join
      wait_for(2, 300, "f4_done");
      bus_read(32'h8F4, "f4_status");

      // NACK: device leaves PS2D high on the 11th clock
      fr_q.push_back(10'h3ED);
      fork
         bus_write(8'hED, 1);
         device_frame(1'b0, "nack");
      join
      wait_for(2, 300, "nack_done");
      check("nack_int", {31'b0, INT}, 32'd1);
      bus_read(32'hAED, "nack_status");
      bus_read(32'h2ED, "nack_status_after_read");

      // Timeout: device never clocks after the start bit
      to_len = 0;
      fork
         bus_write(8'hF4, 1);
         begin
            wait_for(0, 50, "to_inhibit");
            wait_for(1, 200, "to_release");
            while (ps2d_oe === 1'b1 && ps2c_oe === 1'b0 && to_len < 6000) begin
               to_len++;
               tick(1);
            end
         end
      join
      check("to_cycles_after_release", to_len, 32'd5000);
      check("to_ps2c_oe", {31'b0, ps2c_oe}, 32'd0);
      check("to_ps2d_oe", {31'b0, ps2d_oe}, 32'd0);
      check("to_int", {31'b0, INT}, 32'd1);
      bus_read(32'hCF4, "to_status");

      // Held strobe plus a write attempted mid-frame
      inh_before = n_inh;
      fr_q.push_back(10'h355);
      fork
         bus_write(8'h55, 20);
         device_frame(1'b1, "busy");
         begin
            tick(450);
            bus_write(8'hAA, 2);
         end
      join
      wait_for(2, 300, "busy_done");
      tick(200);
      check("busy_one_frame", n_inh - inh_before, 32'd1);
      check("busy_int", {31'b0, INT}, 32'd1);
      bus_read(32'h855, "busy_status");

      // Reset mid-frame: lines must release without a clock edge
      fork
         bus_write(8'hED, 1);
         begin
            wait_for(0, 50, "rstmid_inhibit");
            wait_for(1, 200, "rstmid_release");
         end
      join
      tick(30);
      check("rstmid_pre_d_oe", {31'b0, ps2d_oe}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rstmid_ps2c_oe", {31'b0, ps2c_oe}, 32'd0);
      check("rstmid_ps2d_oe", {31'b0, ps2d_oe}, 32'd0);
      tick(3);
      rst = 1'b0;
      tick(3);
      check("rstmid_dat_o", DAT_O, 32'h0);
      check("rstmid_int", {31'b0, INT}, 32'd0);

      tick(10);
      check("read_queue_drained", rd_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
